// File: rtl/reg_file_bank_if.sv
// reg_file_bank_if
//   Read/write bus between the system controller and the register file.
//   Parameters: WIDTH (data width), ADDR_W (address width).
//   Signals:
//     Wr_En, Rd_En   controller -> bank  write / read strobes (level-sampled)
//     Address        controller -> bank  register index
//     Wr_Data        controller -> bank  write data
//     Rd_Data        bank -> controller  registered read data
//     Rd_Data_Valid  bank -> controller  strobe, the cycle after an accepted read
//   Modports: master = controller side, slave = register-file side.
interface reg_file_bank_if #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned ADDR_W = 4
);
  logic              Wr_En;
  logic              Rd_En;
  logic [ADDR_W-1:0] Address;
  logic [WIDTH-1:0]  Wr_Data;
  logic [WIDTH-1:0]  Rd_Data;
  logic              Rd_Data_Valid;

  modport master (
    output Wr_En, Rd_En, Address, Wr_Data,
    input  Rd_Data, Rd_Data_Valid
  );

  modport slave (
    input  Wr_En, Rd_En, Address, Wr_Data,
    output Rd_Data, Rd_Data_Valid
  );
endinterface

// File: rtl/reg_file_bank.sv
// reg_file_bank
//   DEPTH x WIDTH flop-based register file sitting behind the system
//   controller. Registered reads (1-cycle latency) with a valid strobe;
//   registers 0..3 are exported continuously (ALU A/B, UART config,
//   clock-divider ratio).
// Ports:
//   CLK          system clock, all state on rising edge
//   RST          synchronous reset, active-high
//   bus          reg_file_bank_if.slave (Wr_En, Rd_En, Address, Wr_Data,
//                Rd_Data, Rd_Data_Valid)
//   REG0..REG3   live contents of registers 0..3
//   Cfg_Lock     (RF_CFG_LOCK_EN only) blocks writes to registers 2 and 3
//   Wr_Err       (RF_CFG_LOCK_EN only) one-cycle pulse after a dropped write
// Configuration macro: RF_CFG_LOCK_EN
module reg_file_bank #(
  parameter int unsigned     WIDTH    = 8,
  parameter int unsigned     DEPTH    = 16,
  parameter int unsigned     ADDR_W   = 4,
  parameter logic [WIDTH-1:0] REG2_RST = 8'h81,
  parameter logic [WIDTH-1:0] REG3_RST = 8'h20
) (
  input  logic             CLK,
  input  logic             RST,
  reg_file_bank_if.slave   bus,
`ifdef RF_CFG_LOCK_EN
  input  logic             Cfg_Lock,
  output logic             Wr_Err,
`endif
  output logic [WIDTH-1:0] REG0,
  output logic [WIDTH-1:0] REG1,
  output logic [WIDTH-1:0] REG2,
  output logic [WIDTH-1:0] REG3
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic             in_range;
  logic             rd_accept;
  logic             wr_accept;
  logic [WIDTH-1:0] reg_out [4];

  // When DEPTH covers the whole address space the range check is constant.
  generate
    if (DEPTH >= (32'd1 << ADDR_W)) begin : g_full_range
      assign in_range = 1'b1;
    end else begin : g_part_range
      assign in_range = (32'(bus.Address) < DEPTH);
    end
  endgenerate

  // A collision keeps the write and drops the read.
  assign rd_accept = bus.Rd_En & ~bus.Wr_En;

`ifdef RF_CFG_LOCK_EN
  logic locked;
  logic wr_drop;

  assign locked    = Cfg_Lock &&
                     ((32'(bus.Address) == 32'd2) || (32'(bus.Address) == 32'd3));
  assign wr_drop   = bus.Wr_En & (~in_range | locked);
  assign wr_accept = bus.Wr_En & in_range & ~locked;

  always_ff @(posedge CLK) begin
    if (RST) Wr_Err <= 1'b0;
    else     Wr_Err <= wr_drop;
  end
`else
  assign wr_accept = bus.Wr_En & in_range;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= (i == 2) ? REG2_RST : (i == 3) ? REG3_RST : '0;
      end
    end else if (wr_accept) begin
      mem[bus.Address] <= bus.Wr_Data;
    end
  end

  // Rd_Data holds between reads; out-of-range reads return zero but still
  // raise the valid strobe so the controller is never left waiting.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_accept;
      if (rd_accept) rd_data <= in_range ? mem[bus.Address] : '0;
    end
  end

  assign bus.Rd_Data       = rd_data;
  assign bus.Rd_Data_Valid = rd_valid;

  generate
    for (genvar g = 0; g < 4; g++) begin : g_export
      if (g < DEPTH) begin : g_live
        assign reg_out[g] = mem[g];
      end else begin : g_absent
        assign reg_out[g] = '0;
      end
    end
  endgenerate

  assign REG0 = reg_out[0];
  assign REG1 = reg_out[1];
  assign REG2 = reg_out[2];
  assign REG3 = reg_out[3];

endmodule

// File: tb/tb_reg_file_bank.sv
// tb_reg_file_bank
//   Drives two register banks (DEPTH=16 full address space, DEPTH=12 with
//   out-of-range addresses) with identical stimulus and compares every
//   output against an array-based reference model after each clock edge.
module tb_reg_file_bank;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] R16 [4];
  logic [7:0] R12 [4];
`ifdef RF_CFG_LOCK_EN
  logic       lock;
  logic       err16, err12;
`endif

  always #5 CLK = ~CLK;

  reg_file_bank_if #(.WIDTH(8), .ADDR_W(4)) if16 ();
  reg_file_bank_if #(.WIDTH(8), .ADDR_W(4)) if12 ();

  reg_file_bank #(.WIDTH(8), .DEPTH(16), .ADDR_W(4)) u16 (
    .CLK(CLK), .RST(RST), .bus(if16),
`ifdef RF_CFG_LOCK_EN
    .Cfg_Lock(lock), .Wr_Err(err16),
`endif
    .REG0(R16[0]), .REG1(R16[1]), .REG2(R16[2]), .REG3(R16[3])
  );

  reg_file_bank #(.WIDTH(8), .DEPTH(12), .ADDR_W(4)) u12 (
    .CLK(CLK), .RST(RST), .bus(if12),
`ifdef RF_CFG_LOCK_EN
    .Cfg_Lock(lock), .Wr_Err(err12),
`endif
    .REG0(R12[0]), .REG1(R12[1]), .REG2(R12[2]), .REG3(R12[3])
  );

  // Reference model: index 0 -> DEPTH 16 bank, index 1 -> DEPTH 12 bank.
  int unsigned depth_of [2] = '{16, 12};
  logic [7:0]  m_mem [2][16];
  logic [7:0]  m_rd  [2];
  logic        m_vld [2];
  logic        m_err [2];

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input int b, input logic rst, input logic we, input logic re,
                            input logic [3:0] addr, input logic [7:0] wd, input logic lk);
    bit in_rng, lkd;
    if (rst) begin
      foreach (m_mem[b][k]) m_mem[b][k] = 8'h00;
      m_mem[b][2] = 8'h81;
      m_mem[b][3] = 8'h20;
      m_rd[b]  = 8'h00;
      m_vld[b] = 1'b0;
      m_err[b] = 1'b0;
      return;
    end
    in_rng = (int'(addr) < int'(depth_of[b]));
`ifdef RF_CFG_LOCK_EN
    lkd = lk && (addr == 4'd2 || addr == 4'd3);
`else
    lkd = 1'b0;
`endif
    m_err[b] = we && (!in_rng || lkd);
    m_vld[b] = re && !we;
    if (re && !we) m_rd[b] = in_rng ? m_mem[b][addr] : 8'h00;
    if (we && in_rng && !lkd) m_mem[b][addr] = wd;
  endtask

  task automatic check_all();
    for (int k = 0; k < 4; k++) begin
      check($sformatf("d16_REG%0d", k), R16[k], m_mem[0][k]);
      check($sformatf("d12_REG%0d", k), R12[k], m_mem[1][k]);
    end
    check("d16_Rd_Data", if16.Rd_Data, m_rd[0]);
    check("d12_Rd_Data", if12.Rd_Data, m_rd[1]);
    check("d16_Rd_Data_Valid", {7'd0, if16.Rd_Data_Valid}, {7'd0, m_vld[0]});
    check("d12_Rd_Data_Valid", {7'd0, if12.Rd_Data_Valid}, {7'd0, m_vld[1]});
`ifdef RF_CFG_LOCK_EN
    check("d16_Wr_Err", {7'd0, err16}, {7'd0, m_err[0]});
    check("d12_Wr_Err", {7'd0, err12}, {7'd0, m_err[1]});
`endif
  endtask

  // One clock: drive inputs, take the edge, advance the model, compare.
  task automatic cycle(input logic rst, input logic we, input logic re,
                       input logic [3:0] addr, input logic [7:0] wd, input logic lk);
    RST = rst;
    if16.Wr_En = we; if16.Rd_En = re; if16.Address = addr; if16.Wr_Data = wd;
    if12.Wr_En = we; if12.Rd_En = re; if12.Address = addr; if12.Wr_Data = wd;
`ifdef RF_CFG_LOCK_EN
    lock = lk;
`endif
    @(posedge CLK);
    #1;
    model_step(0, rst, we, re, addr, wd, lk);
    model_step(1, rst, we, re, addr, wd, lk);
    check_all();
  endtask

  initial begin
    // Reset
    cycle(1, 0, 0, 4'd0, 8'h00, 0);
    check("rst_REG2_const", R16[2], 8'h81);
    check("rst_REG3_const", R16[3], 8'h20);
    // Write 5 then read 5, then read drops
    cycle(0, 1, 0, 4'd5, 8'h3C, 0);
    cycle(0, 0, 1, 4'd5, 8'h00, 0);
    check("wr_rd_const", if16.Rd_Data, 8'h3C);
    cycle(0, 0, 0, 4'd5, 8'h00, 0);
    // Held read of 0,1,2
    cycle(0, 1, 0, 4'd0, 8'h11, 0);
    cycle(0, 1, 0, 4'd1, 8'h22, 0);
    cycle(0, 0, 1, 4'd0, 8'h00, 0);
    cycle(0, 0, 1, 4'd1, 8'h00, 0);
    cycle(0, 0, 1, 4'd2, 8'h00, 0);
    check("held_rd_const", if16.Rd_Data, 8'h81);
    cycle(0, 0, 0, 4'd2, 8'h00, 0);
    // Collision, then read back
    cycle(0, 1, 1, 4'd7, 8'hA5, 0);
    cycle(0, 0, 1, 4'd7, 8'h00, 0);
    check("collision_const", if16.Rd_Data, 8'hA5);
    // Out-of-range on the DEPTH 12 bank: write dropped, read returns 0 valid
    cycle(0, 1, 0, 4'd13, 8'h77, 0);
    cycle(0, 0, 1, 4'd13, 8'h00, 0);
    cycle(0, 0, 1, 4'd11, 8'h00, 0);
    // Mid-operation reset with a write to 3
    cycle(0, 0, 1, 4'd3, 8'h00, 0);
    cycle(1, 1, 0, 4'd3, 8'h55, 0);
    check("midrst_REG3_const", R16[3], 8'h20);
`ifdef RF_CFG_LOCK_EN
    cycle(0, 1, 0, 4'd3, 8'h10, 1);
    check("lock_err_const", {7'd0, err16}, 8'h01);
    cycle(0, 1, 0, 4'd4, 8'h44, 1);
    cycle(0, 0, 0, 4'd4, 8'h00, 1);
`endif
    // Randomised traffic
    for (int i = 0; i < 600; i++) begin
      cycle(1'($urandom_range(0, 59) == 0), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 2) != 0), 4'($urandom_range(0, 15)),
            8'($urandom), 1'($urandom_range(0, 1)));
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
